// File: rtl/opsel_pkg.sv
// Shared constants and types for the operand-A selector.
// Optional range check is controlled by OPERAND_A_SEL_RANGE_CHK_EN.
package opsel_pkg;

  localparam int unsigned SRC_REGA  = 0;
  localparam int unsigned SRC_PC1   = 1;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NSRC  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } opsel_state_t;

  // Select width is never below one bit, even for a single-source build.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_a_sel_if.sv
// Request/response bundle between the front end, the selector and the ALU.
// sel_err exists only when OPERAND_A_SEL_RANGE_CHK_EN is defined.
interface operand_a_sel_if #(
  parameter int unsigned WIDTH = opsel_pkg::DEF_WIDTH,
  parameter int unsigned NSRC  = opsel_pkg::DEF_NSRC
);
  localparam int unsigned SELW = opsel_pkg::sel_width(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_sel;
  logic                  out_valid;
  logic                  out_ready;
`ifdef OPERAND_A_SEL_RANGE_CHK_EN
  logic                  sel_err;

  modport master (
    output src_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );
  modport slave (
    input  src_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
`else
  modport master (
    output src_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
  modport slave (
    input  src_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
`endif

endinterface

// File: rtl/opsel_skid.sv
// Generic 2-entry skid buffer: FIFO order, registered in_ready, synchronous flush.
module opsel_skid
  import opsel_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  opsel_state_t  state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          push, pop;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = head_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: head_d = in_data_i;
            2'b10: begin
              tail_d  = in_data_i;
              state_d = TWO;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/operand_a_sel.sv
// Buffered operand-A source selector: source decode in front of a 2-entry skid buffer.
// Define OPERAND_A_SEL_RANGE_CHK_EN to zero out-of-range selects and flag them on sel_err.
module operand_a_sel
  import opsel_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NSRC  = DEF_NSRC
) (
  input logic            clk,
  input logic            rst_n,
  operand_a_sel_if.slave bus
);

  localparam int unsigned SELW = sel_width(NSRC);
  localparam int unsigned EW   = WIDTH + SELW;

  logic [WIDTH-1:0] word;
  logic             in_ready;
  logic             out_valid;
  logic [EW-1:0]    out_entry;

`ifdef OPERAND_A_SEL_RANGE_CHK_EN
  logic in_range;
  logic accept;
  logic sel_err_q;

  assign in_range = 32'(bus.sel) < NSRC;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
`endif

  // Out-of-range indices match no source and fall back to register A.
  always_comb begin
    word = bus.src_data[SRC_REGA*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (bus.sel == SELW'(k)) word = bus.src_data[k*WIDTH +: WIDTH];
    end
`ifdef OPERAND_A_SEL_RANGE_CHK_EN
    if (!in_range) word = '0;
`endif
  end

  opsel_skid #(
    .DW(EW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.flush),
    .in_valid_i (bus.in_valid),
    .in_data_i  ({bus.sel, word}),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_entry),
    .out_ready_i(bus.out_ready)
  );

  assign bus.in_ready                = in_ready;
  assign bus.out_valid               = out_valid;
  assign {bus.out_sel, bus.out_data} = out_entry;

`ifdef OPERAND_A_SEL_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= accept && !in_range;
  end

  assign bus.sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_operand_a_sel.sv
// Directed bench for operand_a_sel with 2-, 3- and 4-source instances.
module tb_operand_a_sel;
  import opsel_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  operand_a_sel_if #(.WIDTH(8), .NSRC(2)) if2 ();
  operand_a_sel_if #(.WIDTH(8), .NSRC(3)) if3 ();
  operand_a_sel_if #(.WIDTH(8), .NSRC(4)) if4 ();

  operand_a_sel #(.WIDTH(8), .NSRC(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  operand_a_sel #(.WIDTH(8), .NSRC(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  operand_a_sel #(.WIDTH(8), .NSRC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {if2.src_data, if2.sel, if2.in_valid, if2.flush, if2.out_ready} = '0;
    {if3.src_data, if3.sel, if3.in_valid, if3.flush, if3.out_ready} = '0;
    {if4.src_data, if4.sel, if4.in_valid, if4.flush, if4.out_ready} = '0;

    #3;
    chk("rst_valid", 32'(if4.out_valid), 0);
    chk("rst_ready", 32'(if4.in_ready), 1);
    chk("rst_data", 32'(if4.out_data), 0);
    chk("rst_sel", 32'(if4.out_sel), 0);
    #9 rst_n = 1'b1;
    tick();

    // Two-source legacy encoding: regA then PC+1
    if2.src_data  = {8'h41, 8'h3C};
    if2.sel       = 1'b0;
    if2.in_valid  = 1'b1;
    if2.out_ready = 1'b1;
    #1 chk("t1_no_passthru", 32'(if2.out_valid), 0);
    tick();
    chk("t1_v0", 32'(if2.out_valid), 1);
    chk("t1_d0", 32'(if2.out_data), 32'h3C);
    chk("t1_s0", 32'(if2.out_sel), 0);
    if2.sel = 1'(SRC_PC1);
    tick();
    chk("t1_v1", 32'(if2.out_valid), 1);
    chk("t1_d1", 32'(if2.out_data), 32'h41);
    chk("t1_s1", 32'(if2.out_sel), 1);
    if2.in_valid = 1'b0;
    tick();
    chk("t1_drain", 32'(if2.out_valid), 0);

    // Stall: third request must be refused
    if4.src_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    if4.out_ready = 1'b0;
    if4.sel       = 2'd1;
    if4.in_valid  = 1'b1;
    tick();
    chk("t2_rdy1", 32'(if4.in_ready), 1);
    chk("t2_d1", 32'(if4.out_data), 32'hB1);
    if4.sel = 2'd2;
    tick();
    chk("t2_rdy2", 32'(if4.in_ready), 0);
    chk("t2_v2", 32'(if4.out_valid), 1);
    chk("t2_d2", 32'(if4.out_data), 32'hB1);
    if4.sel = 2'd3;
    if4.src_data[15:8] = 8'hFF;
    tick();
    chk("t2_rdy3", 32'(if4.in_ready), 0);
    chk("t2_sampled", 32'(if4.out_data), 32'hB1);
    if4.out_ready = 1'b1;
    if4.in_valid  = 1'b0;
    tick();
    chk("t2_pop_d", 32'(if4.out_data), 32'hC2);
    chk("t2_pop_s", 32'(if4.out_sel), 2);
    chk("t2_recover", 32'(if4.in_ready), 1);
    tick();
    chk("t2_empty", 32'(if4.out_valid), 0);

    // Streaming accept+pop in ONE, source 0 ramping
    if4.src_data = '0;
    if4.sel      = 2'd0;
    if4.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t3_d%0d", i), {31'd0, if4.out_valid} << 8 | 32'(if4.out_data),
          32'h100 | 32'(i));
      if4.src_data[7:0] = 8'(i + 1);
    end
    if4.in_valid = 1'b0;
    tick();
    chk("t3_drain", 32'(if4.out_valid), 0);

    // Flush from TWO wins over accept and pop
    if4.src_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    if4.sel       = 2'd2;
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    tick();
    tick();
    chk("t4_full", 32'(if4.in_ready), 0);
    if4.flush     = 1'b1;
    if4.out_ready = 1'b1;
    tick();
    chk("t4_v", 32'(if4.out_valid), 0);
    chk("t4_rdy", 32'(if4.in_ready), 1);
    if4.flush    = 1'b0;
    if4.in_valid = 1'b0;
    tick();
    chk("t4_nothing", 32'(if4.out_valid), 0);

    // Out-of-range select on a 3-source instance
    if3.src_data  = {8'h33, 8'h22, 8'h11};
    if3.sel       = 2'd3;
    if3.in_valid  = 1'b1;
`ifdef OPERAND_A_SEL_RANGE_CHK_EN
    #1 chk("t5_err_pre", 32'(if3.sel_err), 0);
`endif
    tick();
    chk("t5_v", 32'(if3.out_valid), 1);
`ifdef OPERAND_A_SEL_RANGE_CHK_EN
    chk("t5_d", 32'(if3.out_data), 0);
    chk("t5_err", 32'(if3.sel_err), 1);
`else
    chk("t5_d", 32'(if3.out_data), 32'h11);
`endif
    if3.in_valid = 1'b0;
    tick();
`ifdef OPERAND_A_SEL_RANGE_CHK_EN
    chk("t5_err_pulse", 32'(if3.sel_err), 0);
`endif
    chk("t5_in_range_ok", 32'(if3.out_valid), 1);
    if3.out_ready = 1'b1;
    tick();
    chk("t5_drain", 32'(if3.out_valid), 0);

    // Asynchronous reset mid-stall
    if4.sel       = 2'd1;
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    tick();
    tick();
    chk("t6_full", 32'(if4.in_ready), 0);
    chk("t6_d", 32'(if4.out_data), 32'hB1);
    if4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_v", 32'(if4.out_valid), 0);
    chk("t6_data", 32'(if4.out_data), 0);
    chk("t6_rdy", 32'(if4.in_ready), 1);
    chk("t6_sel", 32'(if4.out_sel), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_a_sel.md
# operand_a_sel

Parametrised, buffered operand-A source selector for the MCU datapath. It picks one of NSRC equal-width sources per transaction and presents the selected word to the ALU through a valid/ready handshake. A 2-entry skid buffer lets the front end keep issuing while the ALU stalls. Source index 0 is register A and source 1 is PC+1, so a 2-source instance reproduces the legacy MA select encoding.

## Interface
- WIDTH, 8, data width of every source and of the output
- NSRC, 4, number of sources (2..16)
- SELW, derived localparam = max(1, $clog2(NSRC)), select width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- src_data  in  NSRC*WIDTH  flattened sources; source k is at bits [k*WIDTH +: WIDTH]
- sel  in  SELW  source index for the current request
- in_valid  in  1  request valid
- in_ready  out  1  selector can accept a request
- flush  in  1  synchronous discard of all buffered words
- out_data  out  WIDTH  selected word at the buffer head
- out_sel  out  SELW  source index that produced out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  ALU consumes the head word
- sel_err  out  1  out-of-range select flag (present only with the macro)

## Operation
- Accept: in_valid && in_ready. src_data[sel] and sel are captured together as one entry in the same edge.
- Sources are sampled only at accept. Later changes on src_data do not affect buffered words.
- Pop: out_valid && out_ready removes the head entry.
- Buffer FSM:
  - EMPTY (0 entries) -> ONE on accept.
  - ONE -> EMPTY on pop without accept.
  - ONE -> TWO on accept without pop.
  - ONE stays ONE on accept with pop; the new entry becomes the head.
  - TWO -> ONE on pop. No accept is possible in TWO.
- in_ready = (state != TWO). It is registered and does not depend combinationally on out_ready.
- out_valid = (state != EMPTY). out_data and out_sel always come from the head entry.
- Ordering is strictly FIFO.
- flush: next state is EMPTY. An accept or pop in the same cycle is ignored, and the word is dropped.
- Out-of-range sel (sel >= NSRC): behaviour is set by the macro described under Configuration.
- Reset (asynchronous, any state): state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_sel=0, sel_err=0. Entry storage is cleared to 0.

## Timing
- Latency from accept to out_valid is 1 cycle. Combinational pass-through is not allowed.
- Throughput is 1 word/cycle while out_ready is held high.
- Stall: after out_ready drops, at most 2 further words are accepted. in_ready falls on the edge that fills the buffer (TWO).
- Recovery: in_ready rises the cycle after the first pop from TWO.
- Precedence within one edge: reset, then flush, then pop/accept evaluation.

## Configuration
- OPERAND_A_SEL_RANGE_CHK_EN defined:
  - An out-of-range sel is still accepted.
  - The stored word is all zeros.
  - sel_err is a registered one-cycle pulse on the edge after the accept.
  - The sel_err port exists.
- Not defined:
  - An out-of-range sel selects source 0 (register A).
  - The sel_err port and its logic are absent.
  - No other behaviour changes.

## Structure
- Shared package opsel_pkg holds:
  - the source index constants SRC_REGA=0 and SRC_PC1=1;
  - the 2-bit state typedef opsel_state_t {EMPTY, ONE, TWO};
  - the default WIDTH and NSRC constants.
- Sub-module opsel_skid: a generic 2-entry WIDTH+SELW skid buffer that owns the FSM, flush and the handshake.
- The top level keeps only source decode and range check.

## Test plan
- NSRC=2, sel=0/1, regA=8'h3C, PC+1=8'h41, out_ready=1 -> out_data 3C then 41, one cycle after each accept; out_sel matches.
- NSRC=4, out_ready=0, issue 3 requests -> 2 accepted, in_ready low after the 2nd. Raise out_ready -> both words emerge in order and in_ready returns 1 cycle later.
- Back-to-back accept+pop in ONE for 16 cycles, sources ramping 0..15 -> output 0..15, no bubbles.
- Buffer in TWO; assert flush together with in_valid and out_ready -> next cycle out_valid=0, in_ready=1, nothing emitted.
- NSRC=3, sel=3 -> with the macro: out_data=0 and a sel_err pulse one cycle after accept. Without the macro: out_data=source 0.
- Drop rst_n mid-stall in TWO -> out_valid=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
